// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared constants and types for the multi-port load queue.
//   - LSU_* localparams : default geometry of the load queue and its neighbours
//   - ptr_width()       : width of a circular-buffer pointer incl. wrap bit
//   - load_queue_entry_t: per-entry state visible on the load_queue_entries port
// The entry layout is built from LSU_XLEN, LSU_ROB_TAG_WIDTH and LSU_STQ_SIZE;
// change those here when retargeting the address/tag/store-queue widths.
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam int LSU_XLEN          = 32;
  localparam int LSU_ROB_TAG_WIDTH = 6;
  localparam int LSU_LDQ_SIZE      = 16;
  localparam int LSU_STQ_SIZE      = 16;
  localparam int LSU_NUM_AGU       = 2;
  localparam int LSU_COMMIT_WIDTH  = 2;

  // Index bits plus one wrap bit, so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LDQ_IDX_W = $clog2(LSU_LDQ_SIZE);
  localparam int LDQ_PTR_W = ptr_width(LSU_LDQ_SIZE);
  localparam int STQ_IDX_W = $clog2(LSU_STQ_SIZE);

  typedef struct packed {
    logic                         valid;
    logic [LSU_ROB_TAG_WIDTH-1:0] rob_tag;
    logic [LSU_XLEN-1:0]          address;
    logic                         address_valid;
    logic                         executed;
    logic                         succeeded;
    logic                         committed;
    logic                         order_fail;
    logic [LSU_STQ_SIZE-1:0]      store_mask;
  } load_queue_entry_t;

endpackage

// File: rtl/load_queue_mp_if.sv
// -----------------------------------------------------------------------------
// load_queue_mp_if
// Bundles every load-queue signal except clk/reset.
//   master : dispatch / AGU / ROB / store-queue side (drives requests, sees state)
//   slave  : the load queue itself
// Requests : alloc_*, agu_address_*, load_executed*, load_succeeded*,
//            rob_commit*, store_addr*, store_retire*, flush*
// State    : alloc_ready, order_failures, load_queue_entries, head, tail,
//            full, empty
// -----------------------------------------------------------------------------
interface load_queue_mp_if
  import lsu_pkg::*;
#(
  parameter int XLEN          = LSU_XLEN,
  parameter int ROB_TAG_WIDTH = LSU_ROB_TAG_WIDTH,
  parameter int LDQ_SIZE      = LSU_LDQ_SIZE,
  parameter int STQ_SIZE      = LSU_STQ_SIZE,
  parameter int NUM_AGU       = LSU_NUM_AGU,
  parameter int COMMIT_WIDTH  = LSU_COMMIT_WIDTH
) ();

  localparam int PTR_W   = ptr_width(LDQ_SIZE);
  localparam int STQ_I_W = $clog2(STQ_SIZE);

  // Allocation from dispatch
  logic                              alloc_ldq_entry;
  logic [ROB_TAG_WIDTH-1:0]          rob_tag_in;
  logic [STQ_SIZE-1:0]               store_mask;
  logic                              alloc_ready;
  // Address writeback from the AGUs
  logic [NUM_AGU-1:0]                agu_address_valid;
  logic [NUM_AGU*XLEN-1:0]           agu_address_data;
  logic [NUM_AGU*ROB_TAG_WIDTH-1:0]  agu_address_rob_tag;
  // Execution status
  logic                              load_executed;
  logic [ROB_TAG_WIDTH-1:0]          load_executed_rob_tag;
  logic                              load_succeeded;
  logic [ROB_TAG_WIDTH-1:0]          load_succeeded_rob_tag;
  // ROB commit
  logic [COMMIT_WIDTH-1:0]           rob_commit;
  logic [COMMIT_WIDTH*ROB_TAG_WIDTH-1:0] rob_commit_tag;
  // Store queue
  logic                              store_addr_valid;
  logic [XLEN-1:0]                   store_addr;
  logic [STQ_I_W-1:0]                store_stq_idx;
  logic                              store_retire;
  logic [STQ_I_W-1:0]                store_retire_idx;
  // Branch flush
  logic                              flush;
  logic [PTR_W-1:0]                  flush_tail;
  // Queue state
  logic [LDQ_SIZE-1:0]               order_failures;
  load_queue_entry_t [LDQ_SIZE-1:0]  load_queue_entries;
  logic [PTR_W-1:0]                  head;
  logic [PTR_W-1:0]                  tail;
  logic                              full;
  logic                              empty;

  modport master (
    output alloc_ldq_entry, rob_tag_in, store_mask,
    output agu_address_valid, agu_address_data, agu_address_rob_tag,
    output load_executed, load_executed_rob_tag,
    output load_succeeded, load_succeeded_rob_tag,
    output rob_commit, rob_commit_tag,
    output store_addr_valid, store_addr, store_stq_idx,
    output store_retire, store_retire_idx,
    output flush, flush_tail,
    input  alloc_ready, order_failures, load_queue_entries,
    input  head, tail, full, empty
  );

  modport slave (
    input  alloc_ldq_entry, rob_tag_in, store_mask,
    input  agu_address_valid, agu_address_data, agu_address_rob_tag,
    input  load_executed, load_executed_rob_tag,
    input  load_succeeded, load_succeeded_rob_tag,
    input  rob_commit, rob_commit_tag,
    input  store_addr_valid, store_addr, store_stq_idx,
    input  store_retire, store_retire_idx,
    input  flush, flush_tail,
    output alloc_ready, order_failures, load_queue_entries,
    output head, tail, full, empty
  );

endinterface

// File: rtl/ldq_tag_match.sv
// -----------------------------------------------------------------------------
// ldq_tag_match
// Compares one ROB tag against every load-queue entry.
//   en_i    : request valid; no bits set when low
//   tag_i   : tag to look up
//   valid_i : per-entry valid bits
//   tags_i  : per-entry tags, entry i at [i*TAG_W +: TAG_W]
//   match_o : per-entry hit (one-hot while live tags are unique)
// -----------------------------------------------------------------------------
module ldq_tag_match #(
  parameter int N     = 16,
  parameter int TAG_W = 6
) (
  input  logic               en_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic [N-1:0]       valid_i,
  input  logic [N*TAG_W-1:0] tags_i,
  output logic [N-1:0]       match_o
);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      match_o[i] = en_i && valid_i[i] && (tags_i[i*TAG_W +: TAG_W] == tag_i);
    end
  end

endmodule

// File: rtl/load_queue_mp.sv
// -----------------------------------------------------------------------------
// load_queue_mp
// Circular load queue tracking in-flight loads by ROB tag: address, executed,
// succeeded, committed and memory-order-failure state per entry.
//   clk   : clock
//   reset : synchronous, active-high; clears all entries and pointers
//   lq    : load_queue_mp_if.slave
//           - alloc at tail (dropped while full or during a flush)
//           - NUM_AGU address writebacks, lowest port wins on a shared entry
//           - executed / succeeded / COMMIT_WIDTH commit tag updates
//           - up to COMMIT_WIDTH in-order dequeues per cycle from head
//           - store-address order check and store-retire mask clearing
//           - branch flush rolling the tail back to flush_tail
// Per-entry priority each cycle:
//   reset > flush-invalidate > dequeue-clear > alloc > field updates
// -----------------------------------------------------------------------------
module load_queue_mp
  import lsu_pkg::*;
#(
  parameter int XLEN          = LSU_XLEN,
  parameter int ROB_TAG_WIDTH = LSU_ROB_TAG_WIDTH,
  parameter int LDQ_SIZE      = LSU_LDQ_SIZE,
  parameter int STQ_SIZE      = LSU_STQ_SIZE,
  parameter int NUM_AGU       = LSU_NUM_AGU,
  parameter int COMMIT_WIDTH  = LSU_COMMIT_WIDTH
) (
  input logic            clk,
  input logic            reset,
  load_queue_mp_if.slave lq
);

  localparam int IDX_W = $clog2(LDQ_SIZE);
  localparam int PTR_W = ptr_width(LDQ_SIZE);

  load_queue_entry_t [LDQ_SIZE-1:0] entries_q, entries_d;
  logic [PTR_W-1:0]                 head_q, head_d;
  logic [PTR_W-1:0]                 tail_q, tail_d;

  logic [IDX_W-1:0]           head_idx, tail_idx;
  logic                       full, empty, do_alloc;
  logic [LDQ_SIZE-1:0]        valid_vec;
  logic [LDQ_SIZE*ROB_TAG_WIDTH-1:0] tag_vec;

  logic [LDQ_SIZE-1:0]        agu_hit    [NUM_AGU];
  logic [LDQ_SIZE-1:0]        commit_hit [COMMIT_WIDTH];
  logic [LDQ_SIZE-1:0]        commit_any;
  logic [LDQ_SIZE-1:0]        exec_hit, succ_hit;

  logic [STQ_SIZE-1:0]        retire_mask;
  logic [LDQ_SIZE-1:0]        deq_mask;
  logic [PTR_W-1:0]           deq_count;
  logic [LDQ_SIZE-1:0]        flush_mask;
  logic [PTR_W-1:0]           flush_cnt;
  logic [IDX_W-1:0]           flush_off [LDQ_SIZE];

  // The low two address bits never take part in the word compare.
  logic unused_store_addr_lo;
  assign unused_store_addr_lo = ^lq.store_addr[1:0];

  // ---------------------------------------------------------------------------
  // Occupancy
  // ---------------------------------------------------------------------------
  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign empty    = (head_q == tail_q);
  assign do_alloc = lq.alloc_ldq_entry && !full && !lq.flush;

  // ---------------------------------------------------------------------------
  // Tag lookups against registered entry state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < LDQ_SIZE; i++) begin
      valid_vec[i] = entries_q[i].valid;
      tag_vec[i*ROB_TAG_WIDTH +: ROB_TAG_WIDTH] = entries_q[i].rob_tag;
    end
  end

  for (genvar p = 0; p < NUM_AGU; p++) begin : g_agu_match
    ldq_tag_match #(.N(LDQ_SIZE), .TAG_W(ROB_TAG_WIDTH)) u_match (
      .en_i    (lq.agu_address_valid[p]),
      .tag_i   (lq.agu_address_rob_tag[p*ROB_TAG_WIDTH +: ROB_TAG_WIDTH]),
      .valid_i (valid_vec),
      .tags_i  (tag_vec),
      .match_o (agu_hit[p])
    );
  end

  for (genvar c = 0; c < COMMIT_WIDTH; c++) begin : g_commit_match
    ldq_tag_match #(.N(LDQ_SIZE), .TAG_W(ROB_TAG_WIDTH)) u_match (
      .en_i    (lq.rob_commit[c]),
      .tag_i   (lq.rob_commit_tag[c*ROB_TAG_WIDTH +: ROB_TAG_WIDTH]),
      .valid_i (valid_vec),
      .tags_i  (tag_vec),
      .match_o (commit_hit[c])
    );
  end

  ldq_tag_match #(.N(LDQ_SIZE), .TAG_W(ROB_TAG_WIDTH)) u_exec_match (
    .en_i    (lq.load_executed),
    .tag_i   (lq.load_executed_rob_tag),
    .valid_i (valid_vec),
    .tags_i  (tag_vec),
    .match_o (exec_hit)
  );

  ldq_tag_match #(.N(LDQ_SIZE), .TAG_W(ROB_TAG_WIDTH)) u_succ_match (
    .en_i    (lq.load_succeeded),
    .tag_i   (lq.load_succeeded_rob_tag),
    .valid_i (valid_vec),
    .tags_i  (tag_vec),
    .match_o (succ_hit)
  );

  // ---------------------------------------------------------------------------
  // Dequeue run and flush range
  // ---------------------------------------------------------------------------
  // NOTE: every combinationally assigned signal gets a default at the top of
  // its always_comb block so no path leaves it unassigned and infers a latch.
  always_comb begin
    logic run;
    commit_any  = '0;
    retire_mask = '0;
    deq_mask    = '0;
    deq_count   = '0;
    run         = 1'b1;

    for (int c = 0; c < COMMIT_WIDTH; c++) commit_any |= commit_hit[c];

    if (lq.store_retire) retire_mask[lq.store_retire_idx] = 1'b1;

    // Only an unbroken run of committed entries starting at head may leave.
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (run && entries_q[head_idx + IDX_W'(k)].valid &&
          entries_q[head_idx + IDX_W'(k)].committed) begin
        deq_mask[head_idx + IDX_W'(k)] = 1'b1;
        deq_count = deq_count + PTR_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Entries at circular offset [0, tail - flush_tail) from flush_tail are
  // younger than the mispredicted branch.
  always_comb begin
    flush_cnt = tail_q - lq.flush_tail;
    for (int i = 0; i < LDQ_SIZE; i++) begin
      flush_off[i]  = IDX_W'(i) - lq.flush_tail[IDX_W-1:0];
      flush_mask[i] = lq.flush && ({1'b0, flush_off[i]} < flush_cnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: applied lowest priority first so later steps override
  // ---------------------------------------------------------------------------
  always_comb begin
    entries_d = entries_q;

    for (int i = 0; i < LDQ_SIZE; i++) begin
      // Descending so the lowest-numbered AGU port is written last and wins.
      for (int p = NUM_AGU-1; p >= 0; p--) begin
        if (agu_hit[p][i]) begin
          entries_d[i].address       = lq.agu_address_data[p*XLEN +: XLEN];
          entries_d[i].address_valid = 1'b1;
        end
      end
      if (exec_hit[i])   entries_d[i].executed  = 1'b1;
      if (succ_hit[i])   entries_d[i].succeeded = 1'b1;
      if (commit_any[i]) entries_d[i].committed = 1'b1;

      // Registered executed/address only: a load executing this cycle has not
      // read memory yet, so it cannot have bypassed this store.
      if (lq.store_addr_valid && entries_q[i].valid &&
          entries_q[i].store_mask[lq.store_stq_idx] &&
          entries_q[i].address_valid && entries_q[i].executed &&
          (entries_q[i].address[XLEN-1:2] == lq.store_addr[XLEN-1:2])) begin
        entries_d[i].order_fail = 1'b1;
      end

      entries_d[i].store_mask = entries_d[i].store_mask & ~retire_mask;
    end

    if (do_alloc) begin
      entries_d[tail_idx]            = '0;
      entries_d[tail_idx].valid      = 1'b1;
      entries_d[tail_idx].rob_tag    = lq.rob_tag_in;
      entries_d[tail_idx].store_mask = lq.store_mask & ~retire_mask;
    end

    for (int i = 0; i < LDQ_SIZE; i++) begin
      if (deq_mask[i])   entries_d[i] = '0;
      if (flush_mask[i]) entries_d[i] = '0;
    end

    head_d = head_q + deq_count;
    tail_d = lq.flush ? lq.flush_tail : tail_q + PTR_W'(do_alloc);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: state is assigned with non-blocking <= so every register samples
  // the pre-edge values and the update order inside the block does not matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the entry array is reset in full, not treated as uninitialised
      // storage, because every field is visible on the ports and the valid
      // bits drive the tag matchers from the first cycle.
      entries_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < LDQ_SIZE; i++) lq.order_failures[i] = entries_q[i].order_fail;
  end

  assign lq.load_queue_entries = entries_q;
  assign lq.head               = head_q;
  assign lq.tail               = tail_q;
  assign lq.full               = full;
  assign lq.empty              = empty;
  assign lq.alloc_ready        = !full;

endmodule

// File: tb/tb_load_queue_mp.sv
module tb_load_queue_mp;
  import lsu_pkg::*;

  localparam int N   = LSU_LDQ_SIZE;
  localparam int TW  = LSU_ROB_TAG_WIDTH;
  localparam int XL  = LSU_XLEN;
  localparam int NA  = LSU_NUM_AGU;
  localparam int CW  = LSU_COMMIT_WIDTH;
  localparam int SQ  = LSU_STQ_SIZE;
  localparam int PW  = LDQ_PTR_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_queue_mp_if lq_if ();

  load_queue_mp dut (
    .clk   (clk),
    .reset (reset),
    .lq    (lq_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the queue as an array of entries plus integer pointers
  // counting modulo 2*N.
  load_queue_entry_t m_q [N];
  int m_head = 0;
  int m_tail = 0;

  function automatic int occupancy();
    return (m_tail - m_head + 2*N) % (2*N);
  endfunction

  task automatic clear_inputs();
    reset = 1'b0;
    lq_if.alloc_ldq_entry        = 1'b0;
    lq_if.rob_tag_in             = '0;
    lq_if.store_mask             = '0;
    lq_if.agu_address_valid      = '0;
    lq_if.agu_address_data       = '0;
    lq_if.agu_address_rob_tag    = '0;
    lq_if.load_executed          = 1'b0;
    lq_if.load_executed_rob_tag  = '0;
    lq_if.load_succeeded         = 1'b0;
    lq_if.load_succeeded_rob_tag = '0;
    lq_if.rob_commit             = '0;
    lq_if.rob_commit_tag         = '0;
    lq_if.store_addr_valid       = 1'b0;
    lq_if.store_addr             = '0;
    lq_if.store_stq_idx          = '0;
    lq_if.store_retire           = 1'b0;
    lq_if.store_retire_idx       = '0;
    lq_if.flush                  = 1'b0;
    lq_if.flush_tail             = '0;
  endtask

  // Advances the model by one cycle from the inputs currently driven.
  task automatic model_step();
    load_queue_entry_t nq [N];
    logic [SQ-1:0] rmask;
    int nh, nt, cnt, slot;
    if (reset) begin
      for (int i = 0; i < N; i++) m_q[i] = '0;
      m_head = 0;
      m_tail = 0;
      return;
    end
    nq = m_q;
    nh = m_head;
    nt = m_tail;
    rmask = '0;
    if (lq_if.store_retire) rmask[lq_if.store_retire_idx] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (m_q[i].valid) begin
        for (int p = 0; p < NA; p++) begin
          if (lq_if.agu_address_valid[p] && lq_if.agu_address_rob_tag[p*TW +: TW] == m_q[i].rob_tag) begin
            nq[i].address = lq_if.agu_address_data[p*XL +: XL];
            nq[i].address_valid = 1'b1;
            break;
          end
        end
        if (lq_if.load_executed && lq_if.load_executed_rob_tag == m_q[i].rob_tag) nq[i].executed = 1'b1;
        if (lq_if.load_succeeded && lq_if.load_succeeded_rob_tag == m_q[i].rob_tag) nq[i].succeeded = 1'b1;
        for (int c = 0; c < CW; c++)
          if (lq_if.rob_commit[c] && lq_if.rob_commit_tag[c*TW +: TW] == m_q[i].rob_tag) nq[i].committed = 1'b1;
        if (lq_if.store_addr_valid && m_q[i].store_mask[lq_if.store_stq_idx] && m_q[i].address_valid &&
            m_q[i].executed && (m_q[i].address >> 2) == (lq_if.store_addr >> 2))
          nq[i].order_fail = 1'b1;
      end
      nq[i].store_mask = nq[i].store_mask & ~rmask;
    end
    if (lq_if.alloc_ldq_entry && occupancy() != N && !lq_if.flush) begin
      slot = m_tail % N;
      nq[slot] = '0;
      nq[slot].valid = 1'b1;
      nq[slot].rob_tag = lq_if.rob_tag_in;
      nq[slot].store_mask = lq_if.store_mask & ~rmask;
      nt = (m_tail + 1) % (2*N);
    end
    cnt = 0;
    while (cnt < CW && m_q[(m_head + cnt) % N].valid && m_q[(m_head + cnt) % N].committed) begin
      nq[(m_head + cnt) % N] = '0;
      cnt++;
    end
    nh = (m_head + cnt) % (2*N);
    if (lq_if.flush) begin
      cnt = (m_tail - int'(lq_if.flush_tail) + 2*N) % (2*N);
      for (int k = 0; k < cnt; k++) nq[(int'(lq_if.flush_tail) + k) % N] = '0;
      nt = int'(lq_if.flush_tail);
    end
    m_q = nq;
    m_head = nh;
    m_tail = nt;
  endtask

  // One clock: model update, edge, then sample 1 ns after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic alloc(input int tag, input logic [SQ-1:0] mask);
    lq_if.alloc_ldq_entry = 1'b1;
    lq_if.rob_tag_in = TW'(tag);
    lq_if.store_mask = mask;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    lq_if.alloc_ldq_entry = 1'b1;
    lq_if.rob_tag_in = 6'd7;
    tick();
    n_checks++; if (lq_if.head !== '0) $display("FAIL reset_head: got %0d want 0", lq_if.head); else n_pass++;
    n_checks++; if (lq_if.tail !== '0) $display("FAIL reset_tail: got %0d want 0", lq_if.tail); else n_pass++;
    n_checks++; if (lq_if.empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", lq_if.empty); else n_pass++;
    n_checks++; if (lq_if.full !== 1'b0) $display("FAIL reset_full: got %b want 0", lq_if.full); else n_pass++;
    n_checks++; if (lq_if.alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready: got %b want 1", lq_if.alloc_ready); else n_pass++;
    n_checks++; if (lq_if.order_failures !== '0) $display("FAIL reset_order_failures: got %h want 0", lq_if.order_failures); else n_pass++;
    n_checks++; if (lq_if.load_queue_entries !== '0) $display("FAIL reset_entries: got %h want 0", lq_if.load_queue_entries); else n_pass++;
  endtask

  task automatic test_alloc_agu();
    do_reset();
    alloc(19, '0);
    alloc(20, '0);
    n_checks++; if (lq_if.load_queue_entries[0].valid !== 1'b1 || lq_if.load_queue_entries[0].rob_tag !== 6'd19)
      $display("FAIL alloc_entry0: got v=%b tag=%0d want v=1 tag=19", lq_if.load_queue_entries[0].valid, lq_if.load_queue_entries[0].rob_tag); else n_pass++;
    n_checks++; if (lq_if.load_queue_entries[1].valid !== 1'b1 || lq_if.load_queue_entries[1].rob_tag !== 6'd20)
      $display("FAIL alloc_entry1: got v=%b tag=%0d want v=1 tag=20", lq_if.load_queue_entries[1].valid, lq_if.load_queue_entries[1].rob_tag); else n_pass++;
    n_checks++; if (lq_if.tail !== 5'd2) $display("FAIL alloc_tail: got %0d want 2", lq_if.tail); else n_pass++;
    n_checks++; if (lq_if.empty !== 1'b0) $display("FAIL alloc_empty: got %b want 0", lq_if.empty); else n_pass++;
    lq_if.agu_address_valid = 2'b10;
    lq_if.agu_address_data[2*XL-1:XL] = 32'h40;
    lq_if.agu_address_rob_tag[2*TW-1:TW] = 6'd20;
    tick();
    n_checks++; if (lq_if.load_queue_entries[1].address_valid !== 1'b1 || lq_if.load_queue_entries[1].address !== 32'h40)
      $display("FAIL agu_entry1: got av=%b addr=%h want av=1 addr=40", lq_if.load_queue_entries[1].address_valid, lq_if.load_queue_entries[1].address); else n_pass++;
    n_checks++; if (lq_if.load_queue_entries[0].address_valid !== 1'b0 || lq_if.load_queue_entries[0].address !== '0)
      $display("FAIL agu_entry0_untouched: got av=%b addr=%h want 0/0", lq_if.load_queue_entries[0].address_valid, lq_if.load_queue_entries[0].address); else n_pass++;
    lq_if.agu_address_valid = 2'b11;
    lq_if.agu_address_data = {32'hC0, 32'h80};
    lq_if.agu_address_rob_tag = {6'd19, 6'd19};
    tick();
    n_checks++; if (lq_if.load_queue_entries[0].address !== 32'h80)
      $display("FAIL agu_port_priority: got %h want 80", lq_if.load_queue_entries[0].address); else n_pass++;
  endtask

  task automatic test_full_commit();
    do_reset();
    for (int i = 0; i < N; i++) alloc(i, '0);
    n_checks++; if (lq_if.full !== 1'b1 || lq_if.alloc_ready !== 1'b0)
      $display("FAIL full_flags: got full=%b ready=%b want 1/0", lq_if.full, lq_if.alloc_ready); else n_pass++;
    alloc(40, '0);
    n_checks++; if (lq_if.tail !== 5'b10000) $display("FAIL full_drop_tail: got %0d want 16", lq_if.tail); else n_pass++;
    n_checks++; if (lq_if.load_queue_entries[0].rob_tag !== 6'd0)
      $display("FAIL full_drop_entry0: got tag %0d want 0", lq_if.load_queue_entries[0].rob_tag); else n_pass++;
    lq_if.rob_commit = 2'b11;
    lq_if.rob_commit_tag = {6'd1, 6'd0};
    tick();
    n_checks++; if (lq_if.load_queue_entries[0].committed !== 1'b1 || lq_if.head !== 5'd0)
      $display("FAIL commit_latency: got committed=%b head=%0d want 1/0", lq_if.load_queue_entries[0].committed, lq_if.head); else n_pass++;
    tick();
    n_checks++; if (lq_if.head !== 5'd2) $display("FAIL dequeue_head: got %0d want 2", lq_if.head); else n_pass++;
    n_checks++; if (lq_if.full !== 1'b0) $display("FAIL dequeue_full: got %b want 0", lq_if.full); else n_pass++;
    n_checks++; if (lq_if.load_queue_entries[0].valid !== 1'b0 || lq_if.load_queue_entries[2].valid !== 1'b1)
      $display("FAIL dequeue_entries: got v0=%b v2=%b want 0/1", lq_if.load_queue_entries[0].valid, lq_if.load_queue_entries[2].valid); else n_pass++;
  endtask

  task automatic store_addr(input logic [XL-1:0] a, input int idx);
    lq_if.store_addr_valid = 1'b1;
    lq_if.store_addr = a;
    lq_if.store_stq_idx = STQ_IDX_W'(idx);
  endtask

  task automatic test_order_fail();
    do_reset();
    alloc(5, 16'h0008);
    lq_if.agu_address_valid = 2'b01; lq_if.agu_address_data = {32'h0, 32'h100}; lq_if.agu_address_rob_tag = {6'd0, 6'd5};
    tick();
    lq_if.load_executed = 1'b1; lq_if.load_executed_rob_tag = 6'd5;
    tick();
    alloc(6, 16'h0008);
    lq_if.agu_address_valid = 2'b01; lq_if.agu_address_data = {32'h0, 32'h100}; lq_if.agu_address_rob_tag = {6'd0, 6'd6};
    tick();
    store_addr(32'h102, 3);
    lq_if.load_executed = 1'b1; lq_if.load_executed_rob_tag = 6'd6;
    tick();
    n_checks++; if (lq_if.order_failures !== 16'h0001) $display("FAIL order_flag: got %h want 0001", lq_if.order_failures); else n_pass++;
    n_checks++; if (lq_if.load_queue_entries[1].executed !== 1'b1)
      $display("FAIL order_same_cycle_exec: got %b want 1", lq_if.load_queue_entries[1].executed); else n_pass++;
    store_addr(32'h104, 3);
    tick();
    n_checks++; if (lq_if.order_failures !== 16'h0001) $display("FAIL order_other_word: got %h want 0001", lq_if.order_failures); else n_pass++;
    lq_if.store_retire = 1'b1; lq_if.store_retire_idx = 4'd3;
    tick();
    n_checks++; if (lq_if.load_queue_entries[1].store_mask !== 16'h0000)
      $display("FAIL retire_mask: got %h want 0000", lq_if.load_queue_entries[1].store_mask); else n_pass++;
    store_addr(32'h102, 3);
    tick();
    n_checks++; if (lq_if.order_failures !== 16'h0001) $display("FAIL order_after_retire: got %h want 0001", lq_if.order_failures); else n_pass++;
  endtask

  task automatic test_flush();
    logic [N-1:0] v;
    do_reset();
    for (int t = 1; t <= 6; t++) alloc(t, '0);
    lq_if.flush = 1'b1; lq_if.flush_tail = 5'd2;
    lq_if.alloc_ldq_entry = 1'b1; lq_if.rob_tag_in = 6'd9;
    tick();
    for (int i = 0; i < N; i++) v[i] = lq_if.load_queue_entries[i].valid;
    n_checks++; if (lq_if.tail !== 5'd2) $display("FAIL flush_tail: got %0d want 2", lq_if.tail); else n_pass++;
    n_checks++; if (v !== 16'h0003) $display("FAIL flush_valid: got %h want 0003", v); else n_pass++;
    lq_if.flush = 1'b1; lq_if.flush_tail = 5'd2;
    tick();
    for (int i = 0; i < N; i++) v[i] = lq_if.load_queue_entries[i].valid;
    n_checks++; if (lq_if.tail !== 5'd2 || v !== 16'h0003)
      $display("FAIL flush_noop: got tail=%0d valid=%h want 2/0003", lq_if.tail, v); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int t = 0; t < 14; t++) alloc(t, '0);
    for (int k = 0; k < 7; k++) begin
      lq_if.rob_commit = 2'b11;
      lq_if.rob_commit_tag = {TW'(2*k+1), TW'(2*k)};
      tick();
    end
    tick();
    tick();
    n_checks++; if (lq_if.head !== 5'd14 || lq_if.tail !== 5'd14 || lq_if.empty !== 1'b1)
      $display("FAIL wrap_drain: got head=%0d tail=%0d empty=%b want 14/14/1", lq_if.head, lq_if.tail, lq_if.empty); else n_pass++;
    for (int t = 20; t < 24; t++) alloc(t, '0);
    n_checks++; if (lq_if.tail !== 5'b10010) $display("FAIL wrap_tail: got %b want 10010", lq_if.tail); else n_pass++;
    n_checks++; if (lq_if.full !== 1'b0 || lq_if.empty !== 1'b0)
      $display("FAIL wrap_flags: got full=%b empty=%b want 0/0", lq_if.full, lq_if.empty); else n_pass++;
    n_checks++; if (lq_if.load_queue_entries[15].rob_tag !== 6'd21 || lq_if.load_queue_entries[0].rob_tag !== 6'd22)
      $display("FAIL wrap_slots: got e15=%0d e0=%0d want 21/22", lq_if.load_queue_entries[15].rob_tag, lq_if.load_queue_entries[0].rob_tag); else n_pass++;
  endtask

  task automatic test_reset_mid();
    lq_if.rob_commit = 2'b11;
    lq_if.rob_commit_tag = {6'd21, 6'd20};
    tick();
    lq_if.rob_commit = 2'b11;
    lq_if.rob_commit_tag = {6'd23, 6'd22};
    reset = 1'b1;
    tick();
    n_checks++; if (lq_if.head !== '0 || lq_if.tail !== '0 || lq_if.empty !== 1'b1)
      $display("FAIL reset_mid_ptrs: got head=%0d tail=%0d empty=%b want 0/0/1", lq_if.head, lq_if.tail, lq_if.empty); else n_pass++;
    n_checks++; if (lq_if.load_queue_entries !== '0)
      $display("FAIL reset_mid_entries: got %h want 0", lq_if.load_queue_entries); else n_pass++;
  endtask

  task automatic test_random();
    logic [2*PW+2:0] exp_flags, got_flags;
    logic [N-1:0] exp_of;
    int occ, r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      occ = occupancy();
      reset = ($urandom_range(0, 199) == 0);
      lq_if.alloc_ldq_entry = ($urandom_range(0, 99) < 55);
      lq_if.rob_tag_in = TW'($urandom_range(0, 15));
      lq_if.store_mask = SQ'($urandom);
      for (int p = 0; p < NA; p++) begin
        lq_if.agu_address_valid[p] = $urandom_range(0, 1) == 1;
        lq_if.agu_address_rob_tag[p*TW +: TW] = m_q[$urandom_range(0, N-1)].rob_tag;
        lq_if.agu_address_data[p*XL +: XL] = 32'h100 + XL'($urandom_range(0, 15));
      end
      lq_if.load_executed = $urandom_range(0, 1) == 1;
      lq_if.load_executed_rob_tag = m_q[$urandom_range(0, N-1)].rob_tag;
      lq_if.load_succeeded = $urandom_range(0, 3) == 0;
      lq_if.load_succeeded_rob_tag = m_q[$urandom_range(0, N-1)].rob_tag;
      for (int k = 0; k < CW; k++) begin
        lq_if.rob_commit[k] = $urandom_range(0, 99) < 35;
        lq_if.rob_commit_tag[k*TW +: TW] = m_q[$urandom_range(0, N-1)].rob_tag;
      end
      lq_if.store_addr_valid = $urandom_range(0, 99) < 30;
      lq_if.store_addr = 32'h100 + XL'($urandom_range(0, 15));
      lq_if.store_stq_idx = STQ_IDX_W'($urandom_range(0, SQ-1));
      lq_if.store_retire = $urandom_range(0, 9) == 0;
      lq_if.store_retire_idx = STQ_IDX_W'($urandom_range(0, SQ-1));
      if (occ > CW && $urandom_range(0, 99) < 5) begin
        r = $urandom_range(0, occ - CW);
        lq_if.flush = 1'b1;
        lq_if.flush_tail = PW'((m_tail - r + 2*N) % (2*N));
      end
      tick();
      occ = occupancy();
      exp_flags = {PW'(m_head), PW'(m_tail), occ == N, occ == 0, occ != N};
      got_flags = {lq_if.head, lq_if.tail, lq_if.full, lq_if.empty, lq_if.alloc_ready};
      n_checks++; if (got_flags !== exp_flags)
        $display("FAIL rand_ptrs cyc %0d: got head/tail/full/empty/ready %h want %h", c, got_flags, exp_flags); else n_pass++;
      for (int i = 0; i < N; i++) exp_of[i] = m_q[i].order_fail;
      n_checks++; if (lq_if.order_failures !== exp_of)
        $display("FAIL rand_order_failures cyc %0d: got %h want %h", c, lq_if.order_failures, exp_of); else n_pass++;
      for (int i = 0; i < N; i++) begin
        n_checks++; if (lq_if.load_queue_entries[i] !== m_q[i])
          $display("FAIL rand_entry%0d cyc %0d: got %h want %h", i, c, lq_if.load_queue_entries[i], m_q[i]); else n_pass++;
      end
    end
  endtask

  initial begin
    clear_inputs();
    for (int i = 0; i < N; i++) m_q[i] = '0;
    test_reset();
    test_alloc_agu();
    test_full_commit();
    test_order_fail();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
